// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: radix-configurable shift-add multiplier,
// restoring radix-2 divider, single-cycle fast path for divide-by-zero and overflow.
//   state | meaning
//   IDLE  | waiting for start; fast-path results are issued from here
//   MUL   | shift-add multiply iterations, MUL_BITS multiplier bits per cycle
//   DIV   | restoring divide iterations, one quotient bit per cycle
//   FIX   | sign correction, word select, result/tag/done registered
module mdu_iterative #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 1,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] MUL_ITERS = CNT_W'(XLEN / MUL_BITS);
    localparam logic [CNT_W-1:0] DIV_ITERS = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]          state;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     opnd;      // multiplicand or divisor magnitude
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          op_q;
    logic [TAG_W-1:0]    tag_q;
    logic                neg_q;
    logic                rem_neg_q;

    logic                a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]     a_abs, b_abs;
    logic                div_zero, div_ovf, fast;
    logic [XLEN-1:0]     fast_val;

    logic [MUL_BITS-1:0]      m_bits;
    logic [XLEN+MUL_BITS-1:0] pp, mul_sum;
    logic [2*XLEN-1:0]        mul_next;
    logic [XLEN:0]            r_sh, diff;
    logic [2*XLEN-1:0]        div_next;

    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix, fix_val;

    assign busy = (state != S_IDLE);

    always_comb begin
        a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg    = a_signed && rs1[XLEN-1];
        b_neg    = b_signed && rs2[XLEN-1];
        a_abs    = a_neg ? -rs1 : rs1;
        b_abs    = b_neg ? -rs2 : rs2;
        div_zero = op[2] && (rs2 == '0);
        div_ovf  = ((op == 3'b100) || (op == 3'b110)) && (rs1 == MOST_NEG) && (rs2 == '1);
        fast     = div_zero || div_ovf;
        fast_val = '0;
        // op[1] separates REM/REMU from DIV/DIVU
        if (div_zero)
            fast_val = op[1] ? rs1 : '1;
        else if (div_ovf)
            fast_val = op[1] ? '0 : MOST_NEG;
    end

    always_comb begin
        m_bits   = acc[MUL_BITS-1:0];
        pp       = {{MUL_BITS{1'b0}}, opnd} * {{XLEN{1'b0}}, m_bits};
        mul_sum  = {{MUL_BITS{1'b0}}, acc[2*XLEN-1:XLEN]} + pp;
        mul_next = {mul_sum, acc[XLEN-1:MUL_BITS]};

        // partial remainder gets one extra bit so 2*rem+bit never overflows
        r_sh     = acc[2*XLEN-1:XLEN-1];
        diff     = r_sh - {1'b0, opnd};
        div_next = diff[XLEN] ? {r_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = rem_neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 fix_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = quo_fix;
            default:                fix_val = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            opnd      <= '0;
            cnt       <= '0;
            op_q      <= '0;
            tag_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            tag_out   <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            op_q  <= op;
                            tag_q <= tag_in;
                            if (fast) begin
                                result  <= fast_val;
                                tag_out <= tag_in;
                                done    <= 1'b1;
                            end else if (op[2]) begin
                                state     <= S_DIV;
                                acc       <= {{XLEN{1'b0}}, a_abs};
                                opnd      <= b_abs;
                                cnt       <= DIV_ITERS;
                                neg_q     <= a_neg ^ b_neg;
                                rem_neg_q <= a_neg;
                            end else begin
                                state     <= S_MUL;
                                acc       <= {{XLEN{1'b0}}, b_abs};
                                opnd      <= a_abs;
                                cnt       <= MUL_ITERS;
                                neg_q     <= a_neg ^ b_neg;
                                rem_neg_q <= 1'b0;
                            end
                        end
                    end
                    S_MUL: begin
                        acc <= mul_next;
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE)
                            state <= S_FIX;
                    end
                    S_DIV: begin
                        acc <= div_next;
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE)
                            state <= S_FIX;
                    end
                    S_FIX: begin
                        result  <= fix_val;
                        tag_out <= tag_q;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed and randomized checks of mdu_iterative at MUL_BITS 1, 2 and 4 against
// a plain-arithmetic RV32M reference model.
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0, start2 = 1'b0, start4 = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic [4:0]  tag_in = '0;
    logic        flush = 1'b0;

    logic        busy1, done1, busy2, done2, busy4, done4;
    logic [31:0] res1, res2, res4;
    logic [4:0]  tago1, tago2, tago4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu_iterative #(.XLEN(32), .MUL_BITS(1), .TAG_W(5)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op), .rs1(rs1), .rs2(rs2),
        .tag_in(tag_in), .flush(flush), .busy(busy1), .done(done1),
        .result(res1), .tag_out(tago1));

    mdu_iterative #(.XLEN(32), .MUL_BITS(2), .TAG_W(5)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .op(op), .rs1(rs1), .rs2(rs2),
        .tag_in(tag_in), .flush(flush), .busy(busy2), .done(done2),
        .result(res2), .tag_out(tago2));

    mdu_iterative #(.XLEN(32), .MUL_BITS(4), .TAG_W(5)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op(op), .rs1(rs1), .rs2(rs2),
        .tag_in(tag_in), .flush(flush), .busy(busy4), .done(done4),
        .result(res4), .tag_out(tago4));

    function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // rising edges from the accept edge until done is seen; 0 = done in the very next cycle
    function automatic int exp_edges(input int mb, input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
        if (o[2] && (b == 32'h0 || ((o == 3'b100 || o == 3'b110) &&
                     a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 0;
        if (o[2]) return 33;
        return 32 / mb + 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic get_out(input int sel, output logic bz, output logic dn,
                           output logic [31:0] r, output logic [4:0] t);
        case (sel)
            1:       begin bz = busy1; dn = done1; r = res1; t = tago1; end
            2:       begin bz = busy2; dn = done2; r = res2; t = tago2; end
            default: begin bz = busy4; dn = done4; r = res4; t = tago4; end
        endcase
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            1:       start1 = v;
            2:       start2 = v;
            default: start4 = v;
        endcase
    endtask

    task automatic drive_start(input int sel, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] t);
        op = o; rs1 = a; rs2 = b; tag_in = t;
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
    endtask

    task automatic launch(input int sel, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t);
        @(negedge clk);
        drive_start(sel, o, a, b, t);
    endtask

    task automatic wait_done(input int sel, input int exp_k, input logic [31:0] exp_res,
                             input logic [4:0] exp_tag, input string name);
        int k;
        logic bz, dn, busy_ok;
        logic [31:0] r;
        logic [4:0] t;
        k = 0;
        busy_ok = 1'b1;
        get_out(sel, bz, dn, r, t);
        while (!dn && k < 200) begin
            if (bz !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            k++;
            get_out(sel, bz, dn, r, t);
        end
        chk({name, " latency"}, 64'(k), 64'(exp_k));
        chk({name, " busy while running"}, 64'(busy_ok), 64'(1));
        chk({name, " busy in done cycle"}, 64'(bz), 64'(0));
        chk({name, " result"}, 64'(r), 64'(exp_res));
        chk({name, " tag"}, 64'(t), 64'(exp_tag));
    endtask

    task automatic run_op(input int sel, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t,
                          input logic [31:0] exp_res, input string name);
        logic bz, dn;
        logic [31:0] r;
        logic [4:0] tg;
        launch(sel, o, a, b, t);
        wait_done(sel, exp_edges(sel, o, a, b), exp_res, t, name);
        @(posedge clk); #1;
        get_out(sel, bz, dn, r, tg);
        chk({name, " done pulse width"}, 64'(dn), 64'(0));
    endtask

    task automatic count_dones(input int sel, input int cycles, output int n);
        logic bz, dn;
        logic [31:0] r;
        logic [4:0] t;
        n = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            get_out(sel, bz, dn, r, t);
            if (dn) n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb, r;
        logic [4:0]  t;
        logic        bz, dn;
        int          nd;

        #2 rst = 1'b0;
        #6;
        get_out(1, bz, dn, r, t);
        chk("reset busy", 64'(bz), 64'(0));
        chk("reset done", 64'(dn), 64'(0));
        chk("reset result", 64'(r), 64'(0));
        chk("reset tag", 64'(t), 64'(0));
        @(negedge clk) rst = 1'b1;

        // multiply family, radix 2 bits per cycle = 1
        run_op(1, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, "mul");
        run_op(1, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, "mulh");
        run_op(1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, "mulhsu");
        run_op(1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, "mulhu");

        run_op(1, 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, "divu");
        run_op(1, 3'b111, 32'd100, 32'd7, 5'd6, 32'd2, "remu");
        run_op(1, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, "div neg");
        run_op(1, 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, "rem neg");

        run_op(1, 3'b100, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, "fast div0");
        run_op(1, 3'b111, 32'd5, 32'd0, 5'd11, 32'd5, "fast remu0");
        run_op(1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, "fast div ovf");
        run_op(1, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0, "fast rem ovf");

        // flush mid-op: last reported values are 14 / tag 4
        run_op(1, 3'b101, 32'd100, 32'd7, 5'd4, 32'd14, "pre-flush");
        launch(1, 3'b101, 32'd1000, 32'd3, 5'd21);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        get_out(1, bz, dn, r, t);
        chk("flush busy drop", 64'(bz), 64'(0));
        count_dones(1, 40, nd);
        chk("flush no done", 64'(nd), 64'(0));
        get_out(1, bz, dn, r, t);
        chk("flush result kept", 64'(r), 64'(14));
        chk("flush tag kept", 64'(t), 64'(4));

        // flush coincident with start, iterative and fast-path ops
        @(negedge clk);
        op = 3'b101; rs1 = 32'd50; rs2 = 32'd3; tag_in = 5'd22;
        start1 = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; flush = 1'b0;
        get_out(1, bz, dn, r, t);
        chk("flush+start busy", 64'(bz), 64'(0));
        @(negedge clk);
        op = 3'b100; rs1 = 32'd5; rs2 = 32'd0; tag_in = 5'd23;
        start1 = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; flush = 1'b0;
        get_out(1, bz, dn, r, t);
        chk("flush+fast done", 64'(dn), 64'(0));
        count_dones(1, 40, nd);
        chk("flush+start no done", 64'(nd), 64'(0));
        get_out(1, bz, dn, r, t);
        chk("flush+start result kept", 64'(r), 64'(14));

        // back-to-back: second start issued in the done cycle of the first
        launch(1, 3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
        wait_done(1, 33, ref_mdu(3'b011, 32'h1234_5678, 32'h9ABC_DEF0), 5'd3, "b2b first");
        drive_start(1, 3'b101, 32'd1000, 32'd7, 5'd9);
        get_out(1, bz, dn, r, t);
        chk("b2b first pulse", 64'(dn), 64'(0));
        chk("b2b second accepted", 64'(bz), 64'(1));
        wait_done(1, 33, 32'd142, 5'd9, "b2b second");

        // start pulses while busy are ignored
        launch(1, 3'b101, 32'd1000, 32'd7, 5'd11);
        fork
            begin
                repeat (5) @(posedge clk);
                #2 op = 3'b000; rs1 = 32'd3; rs2 = 32'd3; tag_in = 5'd20; start1 = 1'b1;
                @(posedge clk);
                #2 start1 = 1'b0;
                repeat (10) @(posedge clk);
                #2 start1 = 1'b1;
                @(posedge clk);
                #2 start1 = 1'b0;
            end
        join_none
        wait_done(1, 33, 32'd142, 5'd11, "ignored start");
        count_dones(1, 40, nd);
        chk("ignored start single done", 64'(nd), 64'(0));

        // asynchronous reset mid-multiply
        launch(1, 3'b000, 32'h0001_2345, 32'h0000_0777, 5'd17);
        repeat (10) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        get_out(1, bz, dn, r, t);
        chk("mid reset busy", 64'(bz), 64'(0));
        chk("mid reset done", 64'(dn), 64'(0));
        chk("mid reset result", 64'(r), 64'(0));
        chk("mid reset tag", 64'(t), 64'(0));
        @(negedge clk) rst = 1'b1;
        count_dones(1, 45, nd);
        chk("reset no done", 64'(nd), 64'(0));

        // radix 2 and 4
        for (int mb = 2; mb <= 4; mb += 2) begin
            run_op(mb, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, "radix mul");
            run_op(mb, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, "radix mulh");
            run_op(mb, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, "radix mulhsu");
            run_op(mb, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, "radix mulhu");
            for (int i = 0; i < 6; i++) begin
                ro = 3'($urandom_range(0, 3));
                ra = $urandom;
                rb = $urandom;
                t  = 5'($urandom_range(0, 31));
                run_op(mb, ro, ra, rb, t, ref_mdu(ro, ra, rb), "radix rand");
            end
        end

        // randomized mix of all eight operations
        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            t = 5'($urandom_range(0, 31));
            run_op(1, ro, ra, rb, t, ref_mdu(ro, ra, rb), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
